// File: rtl/t06_apple_spawner.sv
// t06_apple_spawner
// Places 1-3 apples on free cells of the 16x12 snake board. Candidates come
// from a free-running 8-bit LFSR, and an external body checker says whether
// each candidate cell is occupied. Eaten apples are queued again and re-placed.

module t06_apple_spawner #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  state,
    input  logic [1:0]  apple_luck,
    input  logic [2:0]  eaten,
    input  logic        occupied,
    output logic        cand_valid,
    output logic [3:0]  cand_x,
    output logic [3:0]  cand_y,
    output logic [11:0] apple_x,
    output logic [11:0] apple_y,
    output logic [2:0]  apple_valid,
    output logic        busy
);

    localparam logic [1:0] GAME_RUN = 2'b10;

    typedef enum logic {
        IDLE,
        PROBE
    } spawnState_t;

    spawnState_t r_fsm;
    spawnState_t w_fsmNext;

    logic [7:0]  r_lfsr;
    logic        w_feedback;
    logic        r_prevRun;
    logic [1:0]  r_slotCount;
    logic [2:0]  r_pending;
    logic [2:0]  r_appleValid;
    logic [11:0] r_appleX;
    logic [11:0] r_appleY;

    logic        w_inRun;
    logic        w_runEntry;
    logic [3:0]  w_candX;
    logic [3:0]  w_candY;
    logic [2:0]  w_probeOneHot;
    logic        w_collide;
    logic        w_accept;
    logic [2:0]  w_acceptMask;
    logic [2:0]  w_eatMask;
    logic [1:0]  w_countNext;
    logic [2:0]  w_pendingNext;
    logic [2:0]  w_validNext;

    // Luck code to apple count; the unused code 11 falls back to one apple.
    function automatic logic [1:0] luckToCount(input logic [1:0] luck);
        case (luck)
            2'b01:   return 2'd2;
            2'b10:   return 2'd3;
            default: return 2'd1;
        endcase
    endfunction

    // Apple count to the mask of slots that are in use.
    function automatic logic [2:0] countToMask(input logic [1:0] count);
        case (count)
            2'd1:    return 3'b001;
            2'd2:    return 3'b011;
            2'd3:    return 3'b111;
            default: return 3'b000;
        endcase
    endfunction

    assign w_feedback = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Free-running LFSR: steps every cycle regardless of the FSM so that
    // rejected probes always see a fresh candidate on the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= SEED;
        end else begin
            r_lfsr <= {r_lfsr[6:0], w_feedback};
        end
    end

    // Rows 12..15 do not exist, so the upper nibble folds back by 12.
    assign w_candX = r_lfsr[3:0];
    assign w_candY = (r_lfsr[7:4] < 4'd12) ? r_lfsr[7:4] : (r_lfsr[7:4] - 4'd12);

    assign w_inRun    = (state == GAME_RUN);
    assign w_runEntry = w_inRun && !r_prevRun;

    // Remember whether the game was in RUN last cycle to spot RUN entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prevRun <= 1'b0;
        end else begin
            r_prevRun <= w_inRun;
        end
    end

    // The slot being placed is always the lowest-index pending one.
    always_comb begin
        w_probeOneHot = 3'b000;
        if (r_pending[0]) begin
            w_probeOneHot = 3'b001;
        end else if (r_pending[1]) begin
            w_probeOneHot = 3'b010;
        end else if (r_pending[2]) begin
            w_probeOneHot = 3'b100;
        end
    end

    // A candidate also has to avoid every other apple already on the board;
    // the body checker only knows about the snake.
    always_comb begin
        w_collide = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (!w_probeOneHot[j] && r_appleValid[j] &&
                (r_appleX[4*j +: 4] == w_candX) &&
                (r_appleY[4*j +: 4] == w_candY)) begin
                w_collide = 1'b1;
            end
        end
    end

    // Leaving RUN in the middle of a probe throws that probe away.
    assign w_accept     = (r_fsm == PROBE) && w_inRun && (r_pending != 3'b000) &&
                          !occupied && !w_collide;
    assign w_acceptMask = w_accept ? w_probeOneHot : 3'b000;

    // Only apples that are on the board and inside the active count can be eaten.
    assign w_eatMask   = eaten & r_appleValid & countToMask(r_slotCount);
    assign w_countNext = luckToCount(apple_luck);

    // Next pending/valid masks: RUN entry restarts the round from scratch,
    // leaving RUN wipes everything, otherwise accepts and eats are merged.
    always_comb begin
        w_pendingNext = 3'b000;
        w_validNext   = 3'b000;
        if (w_inRun) begin
            if (w_runEntry) begin
                w_pendingNext = countToMask(w_countNext);
                w_validNext   = 3'b000;
            end else begin
                w_pendingNext = (r_pending & ~w_acceptMask) | w_eatMask;
                w_validNext   = (r_appleValid & ~w_eatMask) | w_acceptMask;
            end
        end
    end

    // Slot bookkeeping: apple count latched on RUN entry, pending and valid masks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_slotCount  <= 2'd1;
            r_pending    <= 3'b000;
            r_appleValid <= 3'b000;
        end else begin
            if (w_runEntry) begin
                r_slotCount <= w_countNext;
            end
            r_pending    <= w_pendingNext;
            r_appleValid <= w_validNext;
        end
    end

    // Accepted candidates are written into their slot; positions are kept
    // stale when the round ends so only the valid bits need clearing.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_appleX <= 12'h000;
            r_appleY <= 12'h000;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_acceptMask[i]) begin
                    r_appleX[4*i +: 4] <= w_candX;
                    r_appleY[4*i +: 4] <= w_candY;
                end
            end
        end
    end

    // Spawner FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm <= IDLE;
        end else begin
            r_fsm <= w_fsmNext;
        end
    end

    // Spawner FSM next state: probe while any slot is waiting, and drop back
    // to IDLE as soon as nothing is pending or the game leaves RUN.
    always_comb begin
        w_fsmNext = r_fsm;
        case (r_fsm)
            IDLE: begin
                if (w_inRun && (r_pending != 3'b000)) begin
                    w_fsmNext = PROBE;
                end
            end
            PROBE: begin
                if (!w_inRun || (w_pendingNext == 3'b000)) begin
                    w_fsmNext = IDLE;
                end
            end
            default: begin
                w_fsmNext = IDLE;
            end
        endcase
    end

    assign cand_valid  = (r_fsm == PROBE);
    assign cand_x      = w_candX;
    assign cand_y      = w_candY;
    assign apple_x     = r_appleX;
    assign apple_y     = r_appleY;
    assign apple_valid = r_appleValid;
    assign busy        = |r_pending;

endmodule

// File: tb/tb_t06_apple_spawner.sv
// tb_t06_apple_spawner
// Scenario bench for the apple spawner. A probe-level reference model keeps
// the expected slot positions/valid/pending masks and the LFSR sequence.

module tb_t06_apple_spawner;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  state;
    logic [1:0]  apple_luck;
    logic [2:0]  eaten;
    logic        occupied;
    logic        cand_valid;
    logic [3:0]  cand_x;
    logic [3:0]  cand_y;
    logic [11:0] apple_x;
    logic [11:0] apple_y;
    logic [2:0]  apple_valid;
    logic        busy;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    logic [7:0] mLfsr;
    logic [2:0] mValid;
    logic [2:0] mPend;
    logic [3:0] mX [3];
    logic [3:0] mY [3];
    int         mN;
    int         seenValid;

    t06_apple_spawner #(.SEED(8'hA5)) dut (
        .clk        (clk),
        .rst        (rst),
        .state      (state),
        .apple_luck (apple_luck),
        .eaten      (eaten),
        .occupied   (occupied),
        .cand_valid (cand_valid),
        .cand_x     (cand_x),
        .cand_y     (cand_y),
        .apple_x    (apple_x),
        .apple_y    (apple_y),
        .apple_valid(apple_valid),
        .busy       (busy)
    );

    // 100 MHz clock.
    always #5 clk = ~clk;

    function automatic logic [7:0] lfsrNext(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [3:0] candXOf(input logic [7:0] l);
        return l[3:0];
    endfunction

    function automatic logic [3:0] candYOf(input logic [7:0] l);
        int hi;
        hi = int'(l[7:4]);
        if (hi >= 12) hi = hi - 12;
        return 4'(hi);
    endfunction

    function automatic int lowestSlot(input logic [2:0] m);
        for (int i = 0; i < 3; i++) if (m[i]) return i;
        return 0;
    endfunction

    // Model LFSR: steps on every edge, reseeded while reset is held.
    always @(posedge clk) begin
        if (rst) mLfsr <= 8'hA5;
        else     mLfsr <= lfsrNext(mLfsr);
    end

    // Hang guard.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    // Advance one clock and settle away from the edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive all functional inputs at once.
    task automatic applyStimulus(input logic [1:0] st, input logic [1:0] luck,
                                 input logic [2:0] eat, input logic occ);
        state      = st;
        apple_luck = luck;
        eaten      = eat;
        occupied   = occ;
    endtask

    task automatic modelReset;
        mValid = 3'b000;
        mPend  = 3'b000;
        mN     = 1;
        for (int i = 0; i < 3; i++) begin
            mX[i] = 4'd0;
            mY[i] = 4'd0;
        end
    endtask

    // Pass through SELECT into RUN; the model restarts the round with N slots.
    task automatic enterRun(input logic [1:0] luck, input logic [2:0] eatAtEntry);
        applyStimulus(2'b01, luck, 3'b000, 1'b0);
        tick;
        mValid = 3'b000;
        mPend  = 3'b000;
        applyStimulus(2'b10, luck, eatAtEntry, 1'b0);
        tick;
        eaten = 3'b000;
        mN    = (luck == 2'b01) ? 2 : ((luck == 2'b10) ? 3 : 1);
        mPend = 3'((1 << mN) - 1);
        checks++;
        if (apple_valid !== 3'b000) begin
            errors++;
            $display("[TB] FAIL entry_valid got %b want 000", apple_valid);
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL entry_busy got %b want 1", busy);
        end
    endtask

    // Single-cycle eaten pulse; the model frees only apples that are on the board.
    task automatic pulseEaten(input logic [2:0] mask);
        logic [2:0] hit;
        eaten = mask;
        tick;
        eaten = 3'b000;
        hit    = mask & mValid;
        mValid = mValid & ~hit;
        mPend  = mPend | hit;
        checks++;
        if (apple_valid !== mValid) begin
            errors++;
            $display("[TB] FAIL eaten_valid mask=%b got %b want %b", mask, apple_valid, mValid);
        end
        checks++;
        if (busy !== (mPend != 3'b000)) begin
            errors++;
            $display("[TB] FAIL eaten_busy mask=%b got %b want %b", mask, busy, (mPend != 3'b000));
        end
    endtask

    // Run probes until the model has no pending slot. Called one cycle after
    // pending was set (FSM still idle). Each probe is checked against the model
    // LFSR; occupancy is forced for the first forcedRejects probes, then random
    // or free. Accepts follow the rule: free cell and no clash with other apples.
    task automatic runProbes(input int forcedRejects, input bit randomOcc);
        int         probes;
        int         guard;
        int         p;
        logic [3:0] cx;
        logic [3:0] cy;
        bit         occ;
        bit         acc;
        probes    = 0;
        guard     = 0;
        seenValid = 0;
        checks++;
        if (cand_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL probe_gap cand_valid=%b busy=%b want 0 1", cand_valid, busy);
        end
        tick;
        while (mPend != 3'b000 && guard < 300) begin
            guard++;
            p  = lowestSlot(mPend);
            cx = candXOf(mLfsr);
            cy = candYOf(mLfsr);
            if (cand_valid === 1'b1) seenValid++;
            checks++;
            if (cand_valid !== 1'b1 || cand_x !== cx || cand_y !== cy) begin
                errors++;
                $display("[TB] FAIL probe_cand valid=%b x=%0d y=%0d want 1 x=%0d y=%0d",
                         cand_valid, cand_x, cand_y, cx, cy);
            end
            occ = (probes < forcedRejects) ? 1'b1 : (randomOcc ? 1'($urandom_range(0, 1)) : 1'b0);
            occupied = occ;
            acc = !occ;
            for (int j = 0; j < 3; j++) begin
                if (j != p && mValid[j] && mX[j] == cx && mY[j] == cy) acc = 1'b0;
            end
            probes++;
            tick;
            occupied = 1'b0;
            if (acc) begin
                mX[p]     = cx;
                mY[p]     = cy;
                mValid[p] = 1'b1;
                mPend[p]  = 1'b0;
            end
            checks++;
            if (apple_valid !== mValid || busy !== (mPend != 3'b000)) begin
                errors++;
                $display("[TB] FAIL probe_progress valid=%b busy=%b want %b %b",
                         apple_valid, busy, mValid, (mPend != 3'b000));
            end
        end
        if (guard >= 300) begin
            checks++;
            errors++;
            $display("[TB] FAIL probe_timeout pending model=%b after %0d probes", mPend, guard);
        end
        checks++;
        if (cand_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL probe_done cand_valid got %b want 0", cand_valid);
        end
        for (int i = 0; i < 3; i++) begin
            if (mValid[i]) begin
                checks++;
                if (apple_x[4*i +: 4] !== mX[i] || apple_y[4*i +: 4] !== mY[i]) begin
                    errors++;
                    $display("[TB] FAIL slot_pos slot=%0d got (%0d,%0d) want (%0d,%0d)",
                             i, apple_x[4*i +: 4], apple_y[4*i +: 4], mX[i], mY[i]);
                end
            end
        end
        checks++;
        if (seenValid != probes) begin
            errors++;
            $display("[TB] FAIL probe_count cand_valid cycles got %0d want %0d", seenValid, probes);
        end
    endtask

    // Reset held for three cycles: seed on the candidate outputs, all clear.
    task automatic test_reset;
        applyStimulus(2'b00, 2'b00, 3'b000, 1'b0);
        rst = 1'b1;
        repeat (3) tick;
        modelReset();
        checks++;
        if (cand_x !== 4'd5 || cand_y !== 4'd10) begin
            errors++;
            $display("[TB] FAIL reset_cand got (%0d,%0d) want (5,10)", cand_x, cand_y);
        end
        checks++;
        if (apple_valid !== 3'b000 || busy !== 1'b0 || cand_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags valid=%b busy=%b cand_valid=%b want 000 0 0",
                     apple_valid, busy, cand_valid);
        end
        checks++;
        if (apple_x !== 12'h000 || apple_y !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_pos got x=%h y=%h want 000 000", apple_x, apple_y);
        end
        rst = 1'b0;
        tick;
        checks++;
        if (cand_x !== candXOf(lfsrNext(8'hA5)) || cand_y !== candYOf(lfsrNext(8'hA5))) begin
            errors++;
            $display("[TB] FAIL lfsr_step got (%0d,%0d) want (%0d,%0d)", cand_x, cand_y,
                     candXOf(lfsrNext(8'hA5)), candYOf(lfsrNext(8'hA5)));
        end
    endtask

    // Three apples on an empty board, placed in slot order.
    task automatic test_three_slots;
        enterRun(2'b10, 3'b000);
        runProbes(0, 1'b0);
        checks++;
        if (apple_valid !== 3'b111) begin
            errors++;
            $display("[TB] FAIL three_valid got %b want 111", apple_valid);
        end
        checks++;
        if ({apple_x[3:0], apple_y[3:0]} === {apple_x[7:4], apple_y[7:4]} ||
            {apple_x[3:0], apple_y[3:0]} === {apple_x[11:8], apple_y[11:8]} ||
            {apple_x[7:4], apple_y[7:4]} === {apple_x[11:8], apple_y[11:8]}) begin
            errors++;
            $display("[TB] FAIL three_distinct got x=%h y=%h want pairwise distinct", apple_x, apple_y);
        end
    endtask

    // One apple with the first five probes reported occupied.
    task automatic test_occupied_rejects;
        enterRun(2'b00, 3'b000);
        runProbes(5, 1'b0);
        checks++;
        if (seenValid != 6) begin
            errors++;
            $display("[TB] FAIL reject_probes got %0d want 6", seenValid);
        end
    endtask

    // Eat two of three apples together; both come back without touching slot 1.
    task automatic test_eaten;
        enterRun(2'b10, 3'b000);
        runProbes(0, 1'b1);
        pulseEaten(3'b101);
        checks++;
        if (apple_valid !== 3'b010 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL eat101 valid=%b busy=%b want 010 1", apple_valid, busy);
        end
        runProbes(0, 1'b1);
        checks++;
        if ({apple_x[3:0], apple_y[3:0]} === {apple_x[7:4], apple_y[7:4]} ||
            {apple_x[11:8], apple_y[11:8]} === {apple_x[7:4], apple_y[7:4]}) begin
            errors++;
            $display("[TB] FAIL eat_clash got x=%h y=%h want slots 0,2 off slot 1", apple_x, apple_y);
        end
    endtask

    // Leave RUN during a probe, then come back with a new luck value.
    task automatic test_run_exit;
        enterRun(2'b01, 3'b000);
        tick;
        state    = 2'b00;
        occupied = 1'b0;
        tick;
        mValid = 3'b000;
        mPend  = 3'b000;
        checks++;
        if (apple_valid !== 3'b000 || busy !== 1'b0 || cand_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL exit_flags valid=%b busy=%b cand_valid=%b want 000 0 0",
                     apple_valid, busy, cand_valid);
        end
        checks++;
        if (apple_x !== {mX[2], mX[1], mX[0]} || apple_y !== {mY[2], mY[1], mY[0]}) begin
            errors++;
            $display("[TB] FAIL exit_stale got x=%h y=%h want x=%h y=%h", apple_x, apple_y,
                     {mX[2], mX[1], mX[0]}, {mY[2], mY[1], mY[0]});
        end
        enterRun(2'($urandom_range(0, 3)), 3'b000);
        runProbes(0, 1'b0);
    endtask

    // Luck 11 means a single apple; eats on other slots do nothing.
    task automatic test_luck_three;
        enterRun(2'b11, 3'b111);
        runProbes(0, 1'b0);
        repeat (3) begin
            pulseEaten(3'b110);
            checks++;
            if (apple_valid !== 3'b001 || busy !== 1'b0) begin
                errors++;
                $display("[TB] FAIL luck11_eat valid=%b busy=%b want 001 0", apple_valid, busy);
            end
        end
        tick;
        checks++;
        if (cand_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL luck11_idle cand_valid got %b want 0", cand_valid);
        end
        pulseEaten(3'b001);
        runProbes(0, 1'b1);
    endtask

    // Reset in the middle of a probe beats everything else.
    task automatic test_reset_mid_probe;
        enterRun(2'b10, 3'b000);
        tick;
        rst = 1'b1;
        tick;
        modelReset();
        checks++;
        if (apple_valid !== 3'b000 || busy !== 1'b0 || cand_valid !== 1'b0 ||
            apple_x !== 12'h000 || apple_y !== 12'h000) begin
            errors++;
            $display("[TB] FAIL rst_probe valid=%b busy=%b cv=%b x=%h y=%h want all 0",
                     apple_valid, busy, cand_valid, apple_x, apple_y);
        end
        checks++;
        if (cand_x !== 4'd5 || cand_y !== 4'd10) begin
            errors++;
            $display("[TB] FAIL rst_probe_seed got (%0d,%0d) want (5,10)", cand_x, cand_y);
        end
        state = 2'b00;
        tick;
        rst = 1'b0;
        tick;
    endtask

    // Random rounds: random luck, random occupancy, random eat masks.
    task automatic test_back_to_back;
        for (int round = 0; round < 6; round++) begin
            enterRun(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
            runProbes(0, 1'b1);
            repeat (2) begin
                pulseEaten(3'($urandom_range(0, 7)));
                if (mPend != 3'b000) begin
                    runProbes(0, 1'b1);
                end else begin
                    tick;
                    checks++;
                    if (cand_valid !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL b2b_idle cand_valid got %b want 0", cand_valid);
                    end
                end
            end
        end
    endtask

    // Test sequence.
    initial begin
        rst = 1'b1;
        applyStimulus(2'b00, 2'b00, 3'b000, 1'b0);
        test_reset();
        test_three_slots();
        test_occupied_rejects();
        test_eaten();
        test_run_exit();
        test_luck_three();
        test_reset_mid_probe();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
